div_unit: RTL and testbench

Iterative multi-cycle divide/remainder unit for the RV32M DIV, DIVU, REM and REMU instructions. It sits beside the EX-stage ALU as a responder: the EX stage issues operands with a one-cycle START request, holds the pipeline while BUSY is high, and captures RESULT on the DONE pulse. It uses a radix-2 restoring algorithm (one quotient bit per cycle) in place of a single-cycle combinational divider, and handles the RISC-V divide-by-zero and overflow cases in hardware.

---
 rtl/div_unit.sv | 173 +++++++++++++++++
 tb/tb_div_unit.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
//   Iterative radix-2 restoring divider for RV32M DIV / DIVU / REM / REMU.
//   Sits beside the EX-stage ALU: a one-cycle start request is accepted in
//   IDLE, the unit stays busy while it iterates (one quotient bit per cycle),
//   and the registered result is presented with a one-cycle done pulse.
//   Divide-by-zero and signed overflow are resolved at accept time and skip
//   the iteration entirely.
//
// Ports
//   i_clk      clock, all state updates on the rising edge
//   i_rst_n    synchronous active-low reset
//   i_start    request strobe, only honoured in IDLE
//   i_select   operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   i_data1    dividend, sampled with i_start
//   i_data2    divisor, sampled with i_start
//   o_busy     high whenever the unit is not IDLE
//   o_done     one-cycle pulse, o_result valid in this cycle
//   o_result   quotient or remainder, held until the next accepted request
// -----------------------------------------------------------------------------
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic [1:0]      i_select,
  input  logic [XLEN-1:0] i_data1,
  input  logic [XLEN-1:0] i_data2,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t          r_state;
  logic [1:0]      r_sel;
  logic            r_qneg;
  logic            r_rneg;
  // The partial remainder is always smaller than the divisor after each
  // restoring step, so its 33rd bit is never set once stored; only the trial
  // subtraction needs the extra bit to carry the sign.
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_div;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic            r_done;
  logic [XLEN-1:0] r_result;

  // select[1] picks the remainder, select[0] marks the unsigned variants
  logic            w_is_rem;
  logic            w_is_signed;
  logic [XLEN-1:0] w_dvd_mag;
  logic [XLEN-1:0] w_div_mag;
  logic            w_div_zero;
  logic            w_overflow;
  logic [XLEN:0]   w_shifted;
  logic [XLEN:0]   w_trial;
  logic            w_trial_neg;
  logic [XLEN-1:0] w_rem_nxt;
  logic [XLEN-1:0] w_quo_nxt;
  logic [XLEN-1:0] w_quo_final;
  logic [XLEN-1:0] w_rem_final;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v,
                                                input logic            is_signed);
    return (is_signed && v[XLEN-1]) ? (~v + 1'b1) : v;
  endfunction

  assign w_is_rem    = i_select[1];
  assign w_is_signed = ~i_select[0];
  assign w_dvd_mag   = magnitude(i_data1, w_is_signed);
  assign w_div_mag   = magnitude(i_data2, w_is_signed);
  assign w_div_zero  = (i_data2 == '0);
  assign w_overflow  = w_is_signed && (i_data1 == MIN_NEG) && (i_data2 == '1);

  // One restoring step: bring down the next dividend bit and try to subtract.
  // A set sign bit in the trial means the divisor did not fit.
  assign w_shifted   = {1'b0, r_rem, r_quo[XLEN-1]};
  assign w_trial     = w_shifted - {1'b0, r_div};
  assign w_trial_neg = w_trial[XLEN];
  assign w_rem_nxt   = w_trial_neg ? w_shifted[XLEN-1:0] : w_trial[XLEN-1:0];
  assign w_quo_nxt   = {r_quo[XLEN-2:0], ~w_trial_neg};

  // Sign fix-up: quotient truncates toward zero, remainder follows dividend
  assign w_quo_final = r_qneg ? (~w_quo_nxt + 1'b1) : w_quo_nxt;
  assign w_rem_final = r_rneg ? (~w_rem_nxt + 1'b1) : w_rem_nxt;

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others, exactly like flops.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_sel    <= '0;
      r_qneg   <= 1'b0;
      r_rneg   <= 1'b0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_sel  <= i_select;
            r_qneg <= w_is_signed & (i_data1[XLEN-1] ^ i_data2[XLEN-1]);
            r_rneg <= w_is_signed & i_data1[XLEN-1];
            r_rem  <= '0;
            r_quo  <= w_dvd_mag;
            r_div  <= w_div_mag;
            r_cnt  <= CW'(XLEN - 1);
            r_busy <= 1'b1;
            if (w_div_zero) begin
              r_result <= w_is_rem ? i_data1 : '1;
              r_done   <= 1'b1;
              r_state  <= S_FINISH;
            end else if (w_overflow) begin
              r_result <= w_is_rem ? '0 : MIN_NEG;
              r_done   <= 1'b1;
              r_state  <= S_FINISH;
            end else begin
              r_state  <= S_CALC;
            end
          end
        end

        S_CALC: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt - 1'b1;
          // Last bit: the result is formed from this step's next values so it
          // is already registered when DONE rises in FINISH.
          if (r_cnt == '0) begin
            r_result <= r_sel[1] ? w_rem_final : w_quo_final;
            r_done   <= 1'b1;
            r_state  <= S_FINISH;
          end
        end

        S_FINISH: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_result = r_result;

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit
//   Self-checking bench for div_unit. Directed scenarios cover the basic
//   unsigned and signed cases, the divide-by-zero and overflow shortcuts, the
//   start handshake, and reset mid-operation; a randomized sweep compares the
//   unit against a plain-arithmetic RISC-V div/rem reference.
// -----------------------------------------------------------------------------
module tb_div_unit;

  localparam int XLEN        = 32;
  localparam int LAT_NORMAL  = 33;
  localparam int LAT_SPECIAL = 1;
  localparam int N_RANDOM    = 1200;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [1:0]      sel;
  logic [XLEN-1:0] data1;
  logic [XLEN-1:0] data2;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  int n_cmp = 0;
  int n_bad = 0;

  div_unit #(.XLEN(XLEN)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_start  (start),
    .i_select (sel),
    .i_data1  (data1),
    .i_data2  (data2),
    .o_busy   (busy),
    .o_done   (done),
    .o_result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // RISC-V M-extension semantics computed with 64-bit arithmetic
  function automatic logic [31:0] ref_model(input logic [1:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0]) begin
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      return op[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return op[1] ? (a % b) : (a / b);
  endfunction

  function automatic int ref_latency(input logic [1:0] op,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
    if (b == 32'd0) return LAT_SPECIAL;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return LAT_SPECIAL;
    return LAT_NORMAL;
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 20));
      5:       return 32'(-$urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issues one request from an idle unit and watches it to completion.
  // Entry and exit are 1 time unit after a rising edge. lat is the cycle
  // (counted from the accept edge) in which DONE was seen, -1 on timeout.
  task automatic run_op(input  logic [1:0]  op,
                        input  logic [31:0] a,
                        input  logic [31:0] b,
                        output logic [31:0] res,
                        output int          lat,
                        output int          busy_cycles,
                        output bit          idle_after);
    start = 1'b1;
    sel   = op;
    data1 = a;
    data2 = b;
    @(posedge clk); #1;
    start = 1'b0;
    // scramble inputs so a design that re-reads them gets caught
    data1 = $urandom;
    data2 = $urandom;
    sel   = 2'($urandom);
    lat = -1;
    busy_cycles = 0;
    idle_after = 1'b0;
    res = 'x;
    for (int m = 1; m <= 40; m++) begin
      if (busy) busy_cycles++;
      if (done) begin
        lat = m;
        res = result;
        break;
      end
      @(posedge clk); #1;
    end
    if (lat > 0) begin
      @(posedge clk); #1;
      idle_after = !busy && !done;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    sel   = 2'b00;
    data1 = '0;
    data2 = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (result !== 32'd0) begin n_bad++; $display("FAIL reset_result: got %h want 0", result); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_divu_basic();
    logic [31:0] res;
    int lat, bc;
    bit idl;
    run_op(2'b01, 32'd100, 32'd7, res, lat, bc, idl);
    n_cmp++; if (res !== 32'd14) begin n_bad++; $display("FAIL divu_result: got %h want %h", res, 32'd14); end
    n_cmp++; if (lat !== LAT_NORMAL) begin n_bad++; $display("FAIL divu_latency: got %0d want %0d", lat, LAT_NORMAL); end
    n_cmp++; if (bc !== LAT_NORMAL) begin n_bad++; $display("FAIL divu_busy_cycles: got %0d want %0d", bc, LAT_NORMAL); end
    n_cmp++; if (idl !== 1'b1) begin n_bad++; $display("FAIL divu_idle_after: got %b want 1", idl); end
    run_op(2'b11, 32'd100, 32'd7, res, lat, bc, idl);
    n_cmp++; if (res !== 32'd2) begin n_bad++; $display("FAIL remu_result: got %h want %h", res, 32'd2); end
    n_cmp++; if (lat !== LAT_NORMAL) begin n_bad++; $display("FAIL remu_latency: got %0d want %0d", lat, LAT_NORMAL); end
  endtask

  task automatic test_signed();
    logic [1:0]  ops  [4] = '{2'b00, 2'b10, 2'b10, 2'b00};
    logic [31:0] as   [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000};
    logic [31:0] bs   [4] = '{32'd2, 32'd2, 32'hFFFF_FFFE, 32'd2};
    logic [31:0] want [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1, 32'hC000_0000};
    logic [31:0] res;
    int lat, bc;
    bit idl;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], res, lat, bc, idl);
      n_cmp++; if (res !== want[i]) begin n_bad++; $display("FAIL signed_%0d_result: got %h want %h", i, res, want[i]); end
      n_cmp++; if (lat !== LAT_NORMAL) begin n_bad++; $display("FAIL signed_%0d_latency: got %0d want %0d", i, lat, LAT_NORMAL); end
    end
  endtask

  task automatic test_special();
    logic [1:0]  ops  [6] = '{2'b00, 2'b11, 2'b01, 2'b10, 2'b00, 2'b10};
    logic [31:0] as   [6] = '{32'd5, 32'd5, 32'd5, 32'hFFFF_FFFB, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs   [6] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] want [6] = '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'h8000_0000, 32'd0};
    logic [31:0] res;
    int lat, bc;
    bit idl;
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], as[i], bs[i], res, lat, bc, idl);
      n_cmp++; if (res !== want[i]) begin n_bad++; $display("FAIL special_%0d_result: got %h want %h", i, res, want[i]); end
      n_cmp++; if (lat !== LAT_SPECIAL) begin n_bad++; $display("FAIL special_%0d_latency: got %0d want %0d", i, lat, LAT_SPECIAL); end
      n_cmp++; if (bc !== 1) begin n_bad++; $display("FAIL special_%0d_busy_cycles: got %0d want 1", i, bc); end
      n_cmp++; if (idl !== 1'b1) begin n_bad++; $display("FAIL special_%0d_idle_after: got %b want 1", i, idl); end
    end
  endtask

  // Extra starts during CALC and in FINISH must be ignored, and operand
  // changes after accept must not affect the result.
  task automatic test_handshake();
    int dcount = 0;
    int dm = -1;
    logic [31:0] dres = 'x;
    logic busy34 = 1'bx;
    start = 1'b1;
    sel   = 2'b01;
    data1 = 32'd1000;
    data2 = 32'd3;
    @(posedge clk); #1;
    for (int m = 1; m <= 36; m++) begin
      if (done) begin
        dcount++;
        dm = m;
        dres = result;
      end
      if (m == 34) busy34 = busy;
      start = (m == 5 || m == 33);
      data1 = $urandom;
      data2 = $urandom | 32'd1;
      sel   = 2'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b0;
    n_cmp++; if (dcount !== 1) begin n_bad++; $display("FAIL hs_done_count: got %0d want 1", dcount); end
    n_cmp++; if (dm !== LAT_NORMAL) begin n_bad++; $display("FAIL hs_done_cycle: got %0d want %0d", dm, LAT_NORMAL); end
    n_cmp++; if (dres !== 32'd333) begin n_bad++; $display("FAIL hs_result: got %h want %h", dres, 32'd333); end
    n_cmp++; if (busy34 !== 1'b0) begin n_bad++; $display("FAIL hs_finish_start_ignored: busy got %b want 0", busy34); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    int lat, bc, dcount;
    bit idl;
    run_op(2'b01, 32'd1000, 32'd3, res, lat, bc, idl);
    start = 1'b1;
    sel   = 2'b01;
    data1 = 32'd100;
    data2 = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    for (int m = 1; m < 10; m++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rmid_done: got %b want 0", done); end
    n_cmp++; if (result !== 32'd0) begin n_bad++; $display("FAIL rmid_result: got %h want 0", result); end
    rst_n = 1'b1;
    dcount = 0;
    for (int m = 0; m < 40; m++) begin
      if (done) dcount++;
      @(posedge clk); #1;
    end
    n_cmp++; if (dcount !== 0) begin n_bad++; $display("FAIL rmid_no_done: got %0d pulses want 0", dcount); end
    run_op(2'b01, 32'd100, 32'd7, res, lat, bc, idl);
    n_cmp++; if (res !== 32'd14) begin n_bad++; $display("FAIL rmid_after_result: got %h want %h", res, 32'd14); end
    n_cmp++; if (lat !== LAT_NORMAL) begin n_bad++; $display("FAIL rmid_after_latency: got %0d want %0d", lat, LAT_NORMAL); end
  endtask

  // Back-to-back: each request is issued in the first idle cycle after the
  // previous one, mixing random operands with corner values.
  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a, b, res, want;
    int lat, bc, want_lat;
    bit idl;
    for (int i = 0; i < N_RANDOM; i++) begin
      op = 2'($urandom);
      a  = rand_operand();
      b  = rand_operand();
      want     = ref_model(op, a, b);
      want_lat = ref_latency(op, a, b);
      run_op(op, a, b, res, lat, bc, idl);
      n_cmp++;
      if (res !== want) begin
        n_bad++;
        $display("FAIL rand_%0d_result: op=%b a=%h b=%h got %h want %h", i, op, a, b, res, want);
      end
      n_cmp++;
      if (lat !== want_lat) begin
        n_bad++;
        $display("FAIL rand_%0d_latency: op=%b a=%h b=%h got %0d want %0d", i, op, a, b, lat, want_lat);
      end
      n_cmp++;
      if (idl !== 1'b1) begin
        n_bad++;
        $display("FAIL rand_%0d_idle_after: got %b want 1", i, idl);
      end
    end
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_signed();
    test_special();
    test_handshake();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
